seg7_word_decoder: RTL and testbench
====================================

SEG7_WORD_DECODER -- requirements
Module: seg7_word_decoder

Interface
REQ-001 SHALL have parameter DIGITS, default 6, legal range 1..8: number of 7-segment glyphs assembled per word.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port seg_valid, input, 1: a glyph is offered on seg_data.
REQ-005 SHALL have port seg_ready, output, 1: the block accepts a glyph this cycle.
REQ-006 SHALL have port seg_data, input, 7: active-low glyph, bit order {g,f,e,d,c,b,a}; 0 = segment lit.
REQ-007 SHALL have port abort, input, 1: discard the partially assembled word.
REQ-008 SHALL have port word_valid, output, 1: a completed word is presented.
REQ-009 SHALL have port word_ready, input, 1: the consumer takes the word this cycle.
REQ-010 SHALL have port word_data, output, 4*DIGITS: assembled hex value; first glyph received lands in the most significant nibble.
REQ-011 SHALL have port word_err, output, 1: at least one glyph in word_data was unrecognised.

Function
REQ-012 SHALL decode glyphs to nibbles: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0001000->A, 0000011->B, 1000110->C, 0100001->D, 0000110->E, 0001110->F.
REQ-013 SHALL decode the blank glyph 1111111 as nibble 0 without setting the error flag (leading-blank suppression).
REQ-014 SHALL decode any other glyph as nibble 0 and set the word's error flag.
REQ-015 SHALL implement a two-state FSM: COLLECT (seg_ready=1, word_valid=0) and HOLD (seg_ready=0, word_valid=1).
REQ-016 In COLLECT, SHALL accept a glyph when seg_valid=1, shift the accumulator left by 4 with the decoded nibble in bits [3:0], increment the digit counter, and OR the glyph's error into the error flag.
REQ-017 SHALL transition COLLECT->HOLD on the accept that brings the digit counter to DIGITS, loading word_data/word_err from the accumulator/flag on that same edge (word_valid rises one cycle after the final glyph handshake).
REQ-018 In HOLD, word_data and word_err SHALL remain stable until the word handshake completes; seg_valid SHALL be ignored.
REQ-019 SHALL transition HOLD->COLLECT when word_ready=1, clearing the accumulator, counter and error flag on that edge; the next glyph is accepted no earlier than the following cycle (one-cycle bubble).
REQ-020 In COLLECT, abort=1 SHALL clear the accumulator, counter and error flag; a glyph offered in the same cycle SHALL be dropped (abort wins).
REQ-021 In HOLD, abort SHALL have no effect; the presented word is never retracted.
REQ-022 Digit counter SHALL be 4 bits and never exceed DIGITS.

Reset
REQ-023 With rst_n=0 at a rising edge, SHALL enter COLLECT with seg_ready=1 after the edge, word_valid=0, word_data=0, word_err=0, and accumulator, counter and error flag cleared.
REQ-024 Reset SHALL take priority over abort and both handshakes; a word being held or assembled at reset SHALL be discarded.

Configuration
REQ-025 When macro SEG7_ALT_GLYPH_EN is defined, SHALL additionally decode the alternate glyphs 1011000->7 (with f lit) and 0011000->9 (without d), neither setting the error flag.
REQ-026 When SEG7_ALT_GLYPH_EN is undefined, those two glyphs SHALL be treated as unrecognised per REQ-014.

Verification
REQ-027 DIGITS=6: after reset, feed glyphs 1,2,3,A,B,C back-to-back with seg_valid=1, word_ready=0 -> word_valid=1 one cycle after the sixth accept, word_data=24'h123ABC, word_err=0, seg_ready=0 while held.
REQ-028 Hold word_ready=0 for 5 cycles while toggling seg_valid -> word_data stable and no glyph accepted; then word_ready=1 -> word_valid=0 and seg_ready=1 on the next cycle.
REQ-029 Feed 1111111,1111111,F,F,0,0 -> word_data=24'h00FF00, word_err=0; feed glyph 0110110 as the third digit -> that nibble is 0 and word_err=1.
REQ-030 Accept 3 glyphs, assert abort together with a valid glyph, then feed 6 glyphs 6,5,4,3,2,1 -> word_data=24'h654321 (no stale nibbles, dropped glyph absent).
REQ-031 Assert rst_n=0 during HOLD and during mid-collection -> next cycle word_valid=0, word_data=0, seg_ready=1; next 6 glyphs form a fresh word.
REQ-032 Feed 1011000 as a digit -> decodes to 7 with word_err=0 when SEG7_ALT_GLYPH_EN is defined; decodes to 0 with word_err=1 when it is not.

Source files
------------

// File: rtl/seg7_word_decoder.sv
// seg7_word_decoder
// Collects DIGITS active-low 7-segment glyphs ({g,f,e,d,c,b,a}, 0 = lit)
// into a hex word. The first glyph received lands in the most significant
// nibble. The completed word is held until the consumer takes it.
// Optional feature: define SEG7_ALT_GLYPH_EN to also accept the alternate
// glyph shapes for 7 (with f lit) and 9 (without d).
module seg7_word_decoder #(
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  seg_valid,
    output logic                  seg_ready,
    input  logic [6:0]            seg_data,
    input  logic                  abort,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [4*DIGITS-1:0]   word_data,
    output logic                  word_err
);

    localparam int          WORD_W   = 4 * DIGITS;
    localparam logic [3:0]  DIGITS_C = 4'(DIGITS);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // Glyph decode. Result is {err, nibble}. A blank glyph is legal and
    // reads as 0 so that leading-blank suppressed displays decode cleanly.
    function automatic logic [4:0] decode_glyph(input logic [6:0] g);
        logic [4:0] r;
        case (g)
            7'b1000000: r = {1'b0, 4'h0};
            7'b1111001: r = {1'b0, 4'h1};
            7'b0100100: r = {1'b0, 4'h2};
            7'b0110000: r = {1'b0, 4'h3};
            7'b0011001: r = {1'b0, 4'h4};
            7'b0010010: r = {1'b0, 4'h5};
            7'b0000010: r = {1'b0, 4'h6};
            7'b1111000: r = {1'b0, 4'h7};
            7'b0000000: r = {1'b0, 4'h8};
            7'b0010000: r = {1'b0, 4'h9};
            7'b0001000: r = {1'b0, 4'hA};
            7'b0000011: r = {1'b0, 4'hB};
            7'b1000110: r = {1'b0, 4'hC};
            7'b0100001: r = {1'b0, 4'hD};
            7'b0000110: r = {1'b0, 4'hE};
            7'b0001110: r = {1'b0, 4'hF};
            7'b1111111: r = {1'b0, 4'h0};
`ifdef SEG7_ALT_GLYPH_EN
            7'b1011000: r = {1'b0, 4'h7};
            7'b0011000: r = {1'b0, 4'h9};
`endif
            default:    r = {1'b1, 4'h0};
        endcase
        return r;
    endfunction

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   acc_q, acc_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [WORD_W-1:0]   word_data_q, word_data_d;
    logic                word_err_q, word_err_d;

    logic [4:0]          dec;
    logic [WORD_W-1:0]   acc_shift;
    logic [3:0]          cnt_inc;
    logic                err_acc;

    // Decode the offered glyph and form the candidate accumulator update.
    always_comb begin
        dec       = decode_glyph(seg_data);
        acc_shift = acc_q << 4;
        acc_shift[3:0] = dec[3:0];
        cnt_inc   = cnt_q + 4'd1;
        err_acc   = err_q | dec[4];
    end

    // Next-state and handshake outputs; abort beats a glyph in COLLECT and
    // is ignored in HOLD so a presented word is never retracted.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        word_data_d = word_data_q;
        word_err_d  = word_err_q;
        seg_ready   = 1'b0;
        word_valid  = 1'b0;

        case (state_q)
            COLLECT: begin
                seg_ready = 1'b1;
                if (abort) begin
                    acc_d = '0;
                    cnt_d = 4'd0;
                    err_d = 1'b0;
                end else if (seg_valid) begin
                    acc_d = acc_shift;
                    cnt_d = cnt_inc;
                    err_d = err_acc;
                    if (cnt_inc == DIGITS_C) begin
                        state_d     = HOLD;
                        word_data_d = acc_shift;
                        word_err_d  = err_acc;
                    end
                end
            end
            HOLD: begin
                word_valid = 1'b1;
                if (word_ready) begin
                    state_d = COLLECT;
                    acc_d   = '0;
                    cnt_d   = 4'd0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State and word registers; reset discards anything held or in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            acc_q       <= '0;
            cnt_q       <= 4'd0;
            err_q       <= 1'b0;
            word_data_q <= '0;
            word_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            word_data_q <= word_data_d;
            word_err_q  <= word_err_d;
        end
    end

    assign word_data = word_data_q;
    assign word_err  = word_err_q;

endmodule

// File: tb/tb_seg7_word_decoder.sv
// Scoreboard bench for seg7_word_decoder (DIGITS = 6). Expected words are
// queued when a word's glyphs are issued; a monitor pops one whenever the
// DUT raises word_valid and checks it for as long as it is held.
module tb_seg7_word_decoder;

    localparam logic [6:0] G0  = 7'b1000000;
    localparam logic [6:0] G1  = 7'b1111001;
    localparam logic [6:0] G2  = 7'b0100100;
    localparam logic [6:0] G3  = 7'b0110000;
    localparam logic [6:0] G4  = 7'b0011001;
    localparam logic [6:0] G5  = 7'b0010010;
    localparam logic [6:0] G6  = 7'b0000010;
    localparam logic [6:0] G7  = 7'b1111000;
    localparam logic [6:0] G8  = 7'b0000000;
    localparam logic [6:0] G9  = 7'b0010000;
    localparam logic [6:0] GA  = 7'b0001000;
    localparam logic [6:0] GB  = 7'b0000011;
    localparam logic [6:0] GC  = 7'b1000110;
    localparam logic [6:0] GD  = 7'b0100001;
    localparam logic [6:0] GE  = 7'b0000110;
    localparam logic [6:0] GF  = 7'b0001110;
    localparam logic [6:0] GBL = 7'b1111111;
    localparam logic [6:0] GBAD = 7'b0110110;
    localparam logic [6:0] GALT7 = 7'b1011000;
    localparam logic [6:0] GALT9 = 7'b0011000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        seg_valid;
    logic        seg_ready;
    logic [6:0]  seg_data;
    logic        abort;
    logic        word_valid;
    logic        word_ready;
    logic [23:0] word_data;
    logic        word_err;

    typedef struct packed {
        logic [23:0] d;
        logic        e;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    seg7_word_decoder #(.DIGITS(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_valid  (seg_valid),
        .seg_ready  (seg_ready),
        .seg_data   (seg_data),
        .abort      (abort),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
        .word_err   (word_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Offer one glyph and wait for it to be accepted (bounded).
    task automatic send(input logic [6:0] g);
        int t;
        t = 0;
        seg_valid = 1'b1;
        seg_data  = g;
        @(negedge clk);
        while (seg_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (seg_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: seg_ready=%b, required 1", seg_ready);
        end
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
    endtask

    // Issue six glyphs (first in the top 7 bits), queue the expected word,
    // and check word_valid rises exactly after the sixth accept.
    task automatic send_word(input logic [41:0] gs, input logic [23:0] d, input logic e,
                             input string name);
        exp_t x;
        x.d = d;
        x.e = e;
        exp_q.push_back(x);
        for (int i = 0; i < 6; i++) begin
            send(gs[41-7*i -: 7]);
            if (i == 4) chk({name, "_valid_before_last"}, 32'(word_valid), 32'd0);
        end
        chk({name, "_valid_after_last"}, 32'(word_valid), 32'd1);
        chk({name, "_seg_ready_hold"}, 32'(seg_ready), 32'd0);
    endtask

    task automatic release_word(input string name);
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        word_ready = 1'b0;
        chk({name, "_valid_after_take"}, 32'(word_valid), 32'd0);
        chk({name, "_seg_ready_after_take"}, 32'(seg_ready), 32'd1);
    endtask

    task automatic pulse_reset(input string name);
        rst_n = 1'b0;
        abort = 1'b1;
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        abort = 1'b0;
        word_ready = 1'b0;
        chk({name, "_word_valid"}, 32'(word_valid), 32'd0);
        chk({name, "_word_data"}, 32'(word_data), 32'd0);
        chk({name, "_word_err"}, 32'(word_err), 32'd0);
        chk({name, "_seg_ready"}, 32'(seg_ready), 32'd1);
    endtask

    // Monitor: pop on each new word, then hold it to that value while valid.
    initial begin
        exp_t cur;
        bit   prev_v;
        prev_v = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (mon_en && word_valid === 1'b1) begin
                if (!prev_v) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_word: got %h, required none", word_data);
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                chk("mon_word_data", 32'(word_data), 32'(cur.d));
                chk("mon_word_err", 32'(word_err), 32'(cur.e));
            end
            prev_v = (word_valid === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        seg_valid  = 1'b0;
        seg_data   = GBL;
        abort      = 1'b0;
        word_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_seg_ready", 32'(seg_ready), 32'd1);
        chk("rst_word_valid", 32'(word_valid), 32'd0);
        chk("rst_word_data", 32'(word_data), 32'd0);
        chk("rst_word_err", 32'(word_err), 32'd0);
        mon_en = 1'b1;

        // Basic word, then hold with seg_valid toggling and a stray abort.
        send_word({G1, G2, G3, GA, GB, GC}, 24'h123ABC, 1'b0, "w123abc");
        for (int i = 0; i < 5; i++) begin
            seg_valid = i[0];
            seg_data  = G7;
            abort     = (i == 2);
            @(posedge clk);
            #1;
            chk("hold_seg_ready", 32'(seg_ready), 32'd0);
            chk("hold_word_valid", 32'(word_valid), 32'd1);
        end
        seg_valid = 1'b0;
        abort     = 1'b0;
        release_word("w123abc");

        // Blanks decode to 0 cleanly; an unknown glyph flags the word.
        send_word({GBL, GBL, GF, GF, G0, G0}, 24'h00FF00, 1'b0, "wblank");
        release_word("wblank");
        send_word({GBL, GBL, GBAD, GF, G0, G0}, 24'h000F00, 1'b1, "wbad");
        release_word("wbad");

        // Abort after three glyphs, with a glyph offered in the same cycle.
        send(G1);
        send(G2);
        send(G3);
        seg_valid = 1'b1;
        seg_data  = G9;
        abort     = 1'b1;
        @(posedge clk);
        #1;
        seg_valid = 1'b0;
        abort     = 1'b0;
        send_word({G6, G5, G4, G3, G2, G1}, 24'h654321, 1'b0, "wabort");
        release_word("wabort");

        // Reset during HOLD, then during mid-collection.
        send_word({G7, G8, G9, GD, GE, GF}, 24'h789DEF, 1'b0, "wpre_rst");
        pulse_reset("rst_hold");
        send(G4);
        send(G5);
        send(G6);
        pulse_reset("rst_mid");
        send_word({G8, G9, GD, GE, G7, G4}, 24'h89DE74, 1'b0, "wfresh");
        release_word("wfresh");

        // Alternate glyph shapes for 7 and 9.
`ifdef SEG7_ALT_GLYPH_EN
        send_word({G1, GALT7, GALT9, G0, G0, G0}, 24'h179000, 1'b0, "walt");
`else
        send_word({G1, GALT7, GALT9, G0, G0, G0}, 24'h100000, 1'b1, "walt");
`endif
        release_word("walt");

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
